// File: rtl/sr_drv_pkg.sv
// Shared types and elaboration helpers for the SR latch driver.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_DEAD,
    ST_CHECK
  } state_t;

  // One down-counter serves both the pulse and the dead phase.
  function automatic int cnt_width(input int p, input int d);
    int m;
    m = (p > d) ? p : d;
    return $clog2(m + 1);
  endfunction

  // Dead time below two cycles would let CHECK see stale synchroniser data.
  function automatic bit params_ok(input int p, input int d, input int c);
    return (p >= 1) && (d >= 2) && ((c == 0) || (c == 1));
  endfunction

endpackage

// File: rtl/sr_latch_driver_sync_2ff.sv
// Two-flop synchroniser for the asynchronous latch readback.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives non-overlapping set/reset pulses into an external SR latch and
// verifies the latch readback after every pulse.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int DEAD_CYCLES  = 2,
  parameter int CHECK_EN     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_set,
  input  logic cmd_force,
  output logic s_out,
  output logic r_out,
  input  logic q_in,
  input  logic q_prim_in,
  output logic q_expect,
  output logic state_known,
  output logic busy,
  output logic err_mismatch,
  input  logic err_clr
);

  localparam int CW = cnt_width(PULSE_CYCLES, DEAD_CYCLES);
  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] D_LOAD = CW'(DEAD_CYCLES - 1);

  generate
    if (!params_ok(PULSE_CYCLES, DEAD_CYCLES, CHECK_EN)) begin : g_bad_params
      $error("sr_latch_driver: illegal PULSE_CYCLES/DEAD_CYCLES/CHECK_EN");
    end
  endgenerate

  logic w_q_sync;
  logic w_qp_sync;

  sync_2ff u_sync_q  (.clk(clk), .rst_n(rst_n), .i_d(q_in),      .o_q(w_q_sync));
  sync_2ff u_sync_qp (.clk(clk), .rst_n(rst_n), .i_d(q_prim_in), .o_q(w_qp_sync));

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_set;
  logic          r_s;
  logic          r_r;
  logic          r_ready;
  logic          r_busy;
  logic          r_q_exp;
  logic          r_known;
  logic          r_err;

  logic w_skip;
  assign w_skip = r_known && !cmd_force && (cmd_set == r_q_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_set   <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_q_exp <= 1'b0;
      r_known <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // A mismatch raised in CHECK below overrides this clear.
      if (err_clr) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && !w_skip) begin
            r_set   <= cmd_set;
            r_s     <= cmd_set;
            r_r     <= !cmd_set;
            r_cnt   <= P_LOAD;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_q_exp <= r_set;
            r_known <= 1'b1;
            r_cnt   <= D_LOAD;
            r_state <= ST_DEAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DEAD: begin
          if (r_cnt == '0) r_state <= ST_CHECK;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_CHECK: begin
          if ((CHECK_EN != 0) && ((w_q_sync != r_q_exp) || (w_qp_sync == w_q_sync)))
            r_err <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = r_ready;
  assign s_out        = r_s;
  assign r_out        = r_r;
  assign q_expect     = r_q_exp;
  assign state_known  = r_known;
  assign busy         = r_busy;
  assign err_mismatch = r_err;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: NOR latch model, directed vectors and corner sequences.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_set = 1'b0, cmd_force = 1'b0, err_clr = 1'b0;
  logic cmd_ready, s_out, r_out, q_expect, state_known, busy, err_mismatch;
  logic cmd_ready2, s_out2, r_out2, q_expect2, state_known2, busy2, err_mismatch2;
  logic por = 1'b1;
  logic stuck = 1'b0;
  logic w_q, w_qp, q_in1, qp_in1;
  logic stuck2_q = 1'b0, stuck2_qp = 1'b1;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;
  int err2_seen = 0;

  always #5 clk = ~clk;

  // Cross-coupled NOR latch; por forces a defined start state.
  logic r_lat;
  assign r_lat = r_out | por;
  assign #1 w_q  = ~(r_lat | w_qp);
  assign #1 w_qp = ~(s_out | w_q);
  assign q_in1  = stuck ? 1'b0 : w_q;
  assign qp_in1 = stuck ? 1'b1 : w_qp;

  sr_latch_driver #(.PULSE_CYCLES(4), .DEAD_CYCLES(2), .CHECK_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_set(cmd_set), .cmd_force(cmd_force), .s_out(s_out), .r_out(r_out),
    .q_in(q_in1), .q_prim_in(qp_in1), .q_expect(q_expect), .state_known(state_known),
    .busy(busy), .err_mismatch(err_mismatch), .err_clr(err_clr));

  sr_latch_driver #(.PULSE_CYCLES(4), .DEAD_CYCLES(2), .CHECK_EN(0)) dut_nochk (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_set(cmd_set), .cmd_force(cmd_force), .s_out(s_out2), .r_out(r_out2),
    .q_in(stuck2_q), .q_prim_in(stuck2_qp), .q_expect(q_expect2), .state_known(state_known2),
    .busy(busy2), .err_mismatch(err_mismatch2), .err_clr(err_clr));

  always @(negedge clk) begin
    if ((s_out & r_out) | (s_out2 & r_out2)) overlap_cnt++;
    if (err_mismatch2) err2_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command while idle; record per-cycle activity until ready returns.
  task automatic do_cmd(input logic set, input logic frc,
                        output logic [15:0] s_m, output logic [15:0] r_m,
                        output logic [15:0] b_m, output int rdy);
    s_m = '0; r_m = '0; b_m = '0; rdy = -1;
    cmd_set = set; cmd_force = frc; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      s_m[k] = s_out; r_m[k] = r_out; b_m[k] = busy;
      if (cmd_ready) begin
        rdy = k;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic set;
    logic frc;
    logic pulse;
    logic q_exp;
  } vec_t;

  vec_t vecs[7];
  localparam logic [15:0] PULSE_MASK = 16'h001E;
  localparam logic [15:0] BUSY_MASK  = 16'h00FE;

  initial begin
    logic [15:0] sm, rm, bm;
    int rdy;
    int accepted, cyc, gap, gap_err, pulses;
    logic prev_act, seen, will_acc;

    vecs[0] = '{set: 1'b1, frc: 1'b0, pulse: 1'b1, q_exp: 1'b1};
    vecs[1] = '{set: 1'b1, frc: 1'b0, pulse: 1'b0, q_exp: 1'b1};
    vecs[2] = '{set: 1'b1, frc: 1'b1, pulse: 1'b1, q_exp: 1'b1};
    vecs[3] = '{set: 1'b0, frc: 1'b0, pulse: 1'b1, q_exp: 1'b0};
    vecs[4] = '{set: 1'b0, frc: 1'b0, pulse: 1'b0, q_exp: 1'b0};
    vecs[5] = '{set: 1'b0, frc: 1'b1, pulse: 1'b1, q_exp: 1'b0};
    vecs[6] = '{set: 1'b1, frc: 1'b0, pulse: 1'b1, q_exp: 1'b1};

    #20 por = 1'b0;
    #13;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_s", s_out, 0);
    chk("rst_r", r_out, 0);
    chk("rst_qexp", q_expect, 0);
    chk("rst_known", state_known, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_mismatch, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      do_cmd(vecs[i].set, vecs[i].frc, sm, rm, bm, rdy);
      chk($sformatf("v%0d_smask", i), sm, (vecs[i].pulse && vecs[i].set) ? PULSE_MASK : 16'h0);
      chk($sformatf("v%0d_rmask", i), rm, (vecs[i].pulse && !vecs[i].set) ? PULSE_MASK : 16'h0);
      chk($sformatf("v%0d_busy", i), bm, vecs[i].pulse ? BUSY_MASK : 16'h0);
      chk($sformatf("v%0d_ready_cyc", i), rdy, vecs[i].pulse ? 8 : 1);
      chk($sformatf("v%0d_qexp", i), q_expect, vecs[i].q_exp);
      chk($sformatf("v%0d_known", i), state_known, 1);
      chk($sformatf("v%0d_err", i), err_mismatch, 0);
    end

    // Consecutive skips: accepted every cycle, never a pulse.
    cmd_valid = 1'b1; cmd_set = 1'b1; cmd_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("skip%0d_ready", k), cmd_ready, 1);
      chk($sformatf("skip%0d_s", k), s_out, 0);
    end
    cmd_valid = 1'b0;

    // Back-to-back alternating commands with cmd_valid held.
    accepted = 0; cyc = 0; gap = 0; gap_err = 0; pulses = 0;
    prev_act = 1'b0; seen = 1'b0;
    cmd_set = 1'b0; cmd_force = 1'b0; cmd_valid = 1'b1;
    while (accepted < 20 && cyc < 400) begin
      will_acc = cmd_ready;
      step();
      cyc++;
      if (will_acc) begin
        accepted++;
        cmd_set = ~cmd_set;
        if (accepted == 20) cmd_valid = 1'b0;
      end
      if (s_out | r_out) begin
        if (!prev_act) begin
          if (seen && gap < 2) gap_err++;
          pulses++;
        end
        seen = 1'b1; gap = 0; prev_act = 1'b1;
      end else begin
        gap++; prev_act = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 12 && !cmd_ready; k++) step();
    chk("alt_accepted", accepted, 20);
    chk("alt_gap_err", gap_err, 0);
    chk("alt_pulses", pulses, 20);
    chk("alt_ready", cmd_ready, 1);
    chk("alt_qexp", q_expect, 1);

    // Stuck readback.
    do_cmd(1'b0, 1'b0, sm, rm, bm, rdy);
    chk("pre_stuck_err", err_mismatch, 0);
    stuck = 1'b1;
    do_cmd(1'b1, 1'b0, sm, rm, bm, rdy);
    chk("stuck_ready_cyc", rdy, 8);
    chk("stuck_err", err_mismatch, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", err_mismatch, 0);
    err_clr = 1'b1;
    do_cmd(1'b1, 1'b1, sm, rm, bm, rdy);
    err_clr = 1'b0;
    chk("clr_vs_new_err", err_mismatch, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    stuck = 1'b0;
    chk("err_cleared2", err_mismatch, 0);

    // Reset during the second pulse cycle.
    cmd_set = 1'b1; cmd_force = 1'b1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("midrst_s_before", s_out, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_s", s_out, 0);
    chk("midrst_r", r_out, 0);
    chk("midrst_known", state_known, 0);
    chk("midrst_ready", cmd_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("after_rst_ready", cmd_ready, 1);
    chk("after_rst_known", state_known, 0);
    do_cmd(1'b0, 1'b0, sm, rm, bm, rdy);
    chk("after_rst_rmask", rm, PULSE_MASK);
    chk("after_rst_smask", sm, 16'h0);
    chk("after_rst_known2", state_known, 1);
    chk("after_rst_err", err_mismatch, 0);

    chk("overlap_total", overlap_cnt, 0);
    chk("nochk_err_seen", err2_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
